code_to_vector: RTL and testbench

CODE_TO_VECTOR -- requirements
Module: code_to_vector

---
 rtl/code_to_vector.sv | 112 +++++++++++
 tb/tb_code_to_vector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/code_to_vector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | code_to_vector                                                           |
// | Rebuilds an 8-bit one-hot-union vector from a stream of 4-bit codes and   |
// | presents it with its population count. Optional macro: DUP_CHECK_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module code_to_vector #(
  parameter int MAX_CODES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [3:0] code,
  input  logic       code_last,
  output logic       code_ready,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic [3:0] vec_cnt,
  input  logic       vec_ready,
  output logic       dup_err
);

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;
  localparam logic [3:0] C_LAST_CNT = 4'(MAX_CODES - 1);

  logic [0:0] r_state;
  logic [7:0] r_acc;
  logic [3:0] r_cnt;
  logic [7:0] r_vec;
  logic [3:0] r_vec_cnt;
  logic       r_vec_valid;

  logic       w_accept;
  logic       w_close;
  logic [7:0] w_bit;
  logic [7:0] w_acc_next;
  logic [3:0] w_pop;

  assign code_ready = (r_state == ST_ACC);
  assign w_accept   = code_valid && code_ready;
  assign w_bit      = code[3] ? (8'b1 << code[2:0]) : 8'h00;
  assign w_acc_next = r_acc | w_bit;
  assign w_close    = w_accept && (code_last || (r_cnt == C_LAST_CNT));

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'd0, w_acc_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_acc       <= 8'h00;
      r_cnt       <= 4'd0;
      r_vec       <= 8'h00;
      r_vec_cnt   <= 4'd0;
      r_vec_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_close) begin
            // Closing code's bit is folded straight into the presented vector.
            r_vec       <= w_acc_next;
            r_vec_cnt   <= w_pop;
            r_vec_valid <= 1'b1;
            r_acc       <= 8'h00;
            r_cnt       <= 4'd0;
            r_state     <= ST_OUT;
          end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_OUT: begin
          if (vec_ready) begin
            r_vec_valid <= 1'b0;
            r_acc       <= 8'h00;
            r_cnt       <= 4'd0;
            r_state     <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

`ifdef DUP_CHECK_EN
  logic r_dup;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dup <= 1'b0;
    end else if (w_accept && code[3] && r_acc[code[2:0]]) begin
      r_dup <= 1'b1;
    end
  end

  assign dup_err = r_dup;
`else
  assign dup_err = 1'b0;
`endif

  assign vec       = r_vec;
  assign vec_cnt   = r_vec_cnt;
  assign vec_valid = r_vec_valid;

endmodule
`default_nettype wire

// File: tb/tb_code_to_vector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_code_to_vector                                                        |
// | Directed self-checking bench for code_to_vector.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_code_to_vector;

  logic       clk;
  logic       rst_n;
  logic       code_valid;
  logic [3:0] code;
  logic       code_last;
  logic       code_ready;
  logic       vec_valid;
  logic [7:0] vec;
  logic [3:0] vec_cnt;
  logic       vec_ready;
  logic       dup_err;

  int n_checks;
  int n_fail;

`ifdef DUP_CHECK_EN
  localparam logic C_DUP_EXP = 1'b1;
`else
  localparam logic C_DUP_EXP = 1'b0;
`endif

  code_to_vector #(.MAX_CODES(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .code_last  (code_last),
    .code_ready (code_ready),
    .vec_valid  (vec_valid),
    .vec        (vec),
    .vec_cnt    (vec_cnt),
    .vec_ready  (vec_ready),
    .dup_err    (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic last);
    code_valid = 1'b1;
    code       = c;
    code_last  = last;
    tick();
    code_valid = 1'b0;
    code_last  = 1'b0;
  endtask

  task automatic consume();
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    code_valid = 1'b0;
    code       = 4'h0;
    code_last  = 1'b0;
    vec_ready  = 1'b0;
    tick();
    tick();
    chk("rst_vec_valid", 32'(vec_valid), 32'd0);
    chk("rst_vec", 32'(vec), 32'h00);
    chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    chk("rst_dup", 32'(dup_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_code_ready", 32'(code_ready), 32'd1);

    // Two codes: bit7 and bit0, with vec_ready held high in ACC (ignored).
    vec_ready = 1'b1;
    send(4'b1111, 1'b0);
    chk("acc_ignores_ready", 32'(vec_valid), 32'd0);
    vec_ready = 1'b0;
    send(4'b1000, 1'b1);
    chk("f1_valid", 32'(vec_valid), 32'd1);
    chk("f1_vec", 32'(vec), 32'h81);
    chk("f1_cnt", 32'(vec_cnt), 32'd2);
    chk("f1_ready_low", 32'(code_ready), 32'd0);
    consume();
    chk("f1_cons_valid", 32'(vec_valid), 32'd0);
    chk("f1_cons_ready", 32'(code_ready), 32'd1);

    // Empty-vector code only.
    send(4'b0000, 1'b1);
    chk("f2_valid", 32'(vec_valid), 32'd1);
    chk("f2_vec", 32'(vec), 32'h00);
    chk("f2_cnt", 32'(vec_cnt), 32'd0);

    // Back-pressure: a code offered while OUT must not be taken.
    code_valid = 1'b1;
    code       = 4'b1111;
    code_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_vec", 32'(vec), 32'h00);
      chk("hold_valid", 32'(vec_valid), 32'd1);
      chk("hold_code_ready", 32'(code_ready), 32'd0);
    end
    vec_ready = 1'b1;
    tick();
    code_valid = 1'b0;
    code_last  = 1'b0;
    vec_ready  = 1'b0;
    chk("hold_rel_valid", 32'(vec_valid), 32'd0);
    chk("hold_rel_ready", 32'(code_ready), 32'd1);
    send(4'b0001, 1'b1);
    chk("no_leak_vec", 32'(vec), 32'h00);
    consume();

    // MAX_CODES closure with no last.
    for (int i = 0; i < 8; i++) begin
      send(4'(8 + i), 1'b0);
      if (i == 6) chk("max_not_yet", 32'(vec_valid), 32'd0);
    end
    chk("max_valid", 32'(vec_valid), 32'd1);
    chk("max_vec", 32'(vec), 32'hFF);
    chk("max_cnt", 32'(vec_cnt), 32'd8);
    consume();

    // Duplicate index.
    send(4'b1010, 1'b0);
    send(4'b1010, 1'b1);
    chk("dup_vec", 32'(vec), 32'h04);
    chk("dup_cnt", 32'(vec_cnt), 32'd1);
    chk("dup_flag", 32'(dup_err), 32'(C_DUP_EXP));
    consume();
    send(4'b1001, 1'b1);
    chk("dup_next_vec", 32'(vec), 32'h02);
    chk("dup_sticky", 32'(dup_err), 32'(C_DUP_EXP));
    consume();

    // Reset mid-frame discards partial accumulation.
    send(4'b1001, 1'b0);
    send(4'b1100, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(vec_valid), 32'd0);
    chk("midrst_dup", 32'(dup_err), 32'd0);
    tick();
    chk("midrst_still_idle", 32'(vec_valid), 32'd0);
    send(4'b1011, 1'b1);
    chk("midrst_vec", 32'(vec), 32'h08);
    chk("midrst_cnt", 32'(vec_cnt), 32'd1);

    // Reset while a vector is pending.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("outrst_valid", 32'(vec_valid), 32'd0);
    chk("outrst_ready", 32'(code_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
